// File: rtl/fibonacci_stream_if.sv
// Output beat stream of fibonacci_stream: valid/ready handshake carrying
// LANES terms per beat together with a lane mask and an end-of-run flag.
interface fibonacci_stream_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 2
);
  logic                   valid;
  logic                   ready;
  logic [LANES*WIDTH-1:0] data;
  logic [LANES-1:0]       mask;
  logic                   last;

  modport master (output valid, data, mask, last, input ready);
  modport slave  (input valid, data, mask, last, output ready);
endinterface

// File: rtl/fibonacci_stream.sv
// Multi-lane two-seed recurrence generator: LANES consecutive terms per beat.
// Define FIBONACCI_STREAM_SATURATE_EN to clamp overflowing sums to all-ones.
module fibonacci_stream #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int LEN_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [WIDTH-1:0]    seed0_i,
  input  logic [WIDTH-1:0]    seed1_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                ovf_o,
  output logic                done_o,
  fibonacci_stream_if.master  out_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ca_q, ca_d, cb_q, cb_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0]       term  [LANES+2];
  logic                   carry [LANES+2];
  logic [LANES-1:0]       mask;
  logic [LANES*WIDTH-1:0] data;
  logic                   run, last, fire, beat_ovf;

  assign run  = (state_q == S_RUN);
  assign last = run && (rem_q <= LEN_W'(LANES));
  assign fire = run && out_if.ready;

  // Carry flags travel with the pair so a term that wrapped while being
  // precomputed is only reported once it is actually emitted.
  always_comb begin
    term[0]  = a_q;
    term[1]  = b_q;
    carry[0] = ca_q;
    carry[1] = cb_q;
    for (int unsigned i = 2; i < LANES + 2; i++) begin
      {carry[i], term[i]} = {1'b0, term[i-1]} + {1'b0, term[i-2]};
`ifdef FIBONACCI_STREAM_SATURATE_EN
      if (carry[i]) term[i] = '1;
`endif
    end
  end

  always_comb begin
    mask     = '0;
    data     = '0;
    beat_ovf = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      mask[i]                = run && (rem_q > LEN_W'(i));
      data[i*WIDTH +: WIDTH] = term[i];
      if (mask[i] && carry[i]) beat_ovf = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ca_d    = ca_q;
    cb_d    = cb_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ovf_d = 1'b0;
          if (len_i != '0) begin
            a_d     = seed0_i;
            b_d     = seed1_i;
            ca_d    = 1'b0;
            cb_d    = 1'b0;
            rem_d   = len_i;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        ovf_d = ovf_q | beat_ovf;
        if (fire) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            a_d   = term[LANES];
            ca_d  = carry[LANES];
            b_d   = term[LANES+1];
            cb_d  = carry[LANES+1];
            rem_d = rem_q - LEN_W'(LANES);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ca_q    <= 1'b0;
      cb_q    <= 1'b0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.valid = run;
  assign out_if.data  = data;
  assign out_if.mask  = mask;
  assign out_if.last  = last;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign ovf_o        = ovf_q | beat_ovf;

endmodule

// File: tb/tb_fibonacci_stream.sv
// Scoreboard bench for fibonacci_stream: a term-list model queues expected
// beats, an independent negedge monitor pops and compares on each handshake.
module tb_fibonacci_stream;
  localparam int W  = 16;
  localparam int L  = 2;
  localparam int LW = 16;
  localparam int unsigned MAXV = (1 << W) - 1;

  typedef struct {
    logic [L*W-1:0] data;
    logic [L-1:0]   mask;
    logic           last;
    logic           ovf;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  seed0, seed1;
  logic [LW-1:0] len_s;
  logic          busy, ovf, done;

  fibonacci_stream_if #(.WIDTH(W), .LANES(L)) sif ();

  fibonacci_stream #(.WIDTH(W), .LANES(L), .LEN_W(LW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .seed0_i (seed0),
    .seed1_i (seed1),
    .len_i   (len_s),
    .busy_o  (busy),
    .ovf_o   (ovf),
    .done_o  (done),
    .out_if  (sif)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    done_cnt = 0;
  int    hs_cnt = 0;
  beat_t exp_q[$];
  bit    rdy_pat[$];
  bit    rdy_rand = 1'b0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: explicit term list F(0..len-1), sliced into beats of L lanes.
  function automatic bit model(input logic [W-1:0] s0, input logic [W-1:0] s1,
                               input int len, output bit first_ovf);
    int unsigned term[$];
    bit          ov[$];
    bit          acc = 1'b0;
    first_ovf = 1'b0;
    term.push_back(s0); term.push_back(s1);
    ov.push_back(1'b0); ov.push_back(1'b0);
    for (int n = 2; n < len; n++) begin
      int unsigned sum;
      bit          c;
      sum = term[n-1] + term[n-2];
      c   = (sum > MAXV);
`ifdef FIBONACCI_STREAM_SATURATE_EN
      term.push_back(c ? MAXV : sum);
`else
      term.push_back(sum & MAXV);
`endif
      ov.push_back(c);
    end
    for (int k = 0; k * L < len; k++) begin
      beat_t b;
      b.data = '0;
      b.mask = '0;
      for (int i = 0; i < L; i++) begin
        int idx;
        idx = k * L + i;
        if (idx < len) begin
          b.data[i*W +: W] = term[idx][W-1:0];
          b.mask[i] = 1'b1;
          acc = acc | ov[idx];
        end
      end
      b.last = ((k + 1) * L >= len);
      b.ovf  = acc;
      if (k == 0) first_ovf = acc;
      exp_q.push_back(b);
    end
    return acc;
  endfunction

  // Ready driver, offset from the start driver so pattern alignment is deterministic.
  initial begin
    sif.ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (rdy_pat.size() > 0) sif.ready = rdy_pat.pop_front();
      else if (rdy_rand)      sif.ready = 1'($urandom_range(0, 1));
      else                    sif.ready = 1'b1;
    end
  end

  // Monitor: handshake comparison, stall stability, done pulse width.
  initial begin
    bit             stall = 1'b0;
    bit             prev_done = 1'b0;
    logic [L*W-1:0] h_data;
    logic [L-1:0]   h_mask;
    logic           h_last;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (sif.valid) begin
          if (stall) begin
            chk("hold_data", sif.data, h_data);
            chk("hold_mask", sif.mask, h_mask);
            chk("hold_last", sif.last, h_last);
          end
          if (sif.ready) begin
            hs_cnt++;
            stall = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
              beat_t          e;
              logic [L*W-1:0] lm;
              e  = exp_q.pop_front();
              lm = '0;
              for (int i = 0; i < L; i++) if (e.mask[i]) lm[i*W +: W] = '1;
              chk("beat_data", sif.data & lm, e.data);
              chk("beat_mask", sif.mask, e.mask);
              chk("beat_last", sif.last, e.last);
              chk("beat_ovf", ovf, e.ovf);
            end
          end else begin
            stall  = 1'b1;
            h_data = sif.data;
            h_mask = sif.mask;
            h_last = sif.last;
          end
        end else begin
          stall = 1'b0;
        end
        if (done) begin
          done_cnt++;
          chk("done_width", prev_done, 1'b0);
          chk("done_busy", busy, 1'b1);
        end
        prev_done = done;
      end
    end
  end

  task automatic check_reset_outs();
    chk("rst_valid", sif.valid, 1'b0);
    chk("rst_busy",  busy,      1'b0);
    chk("rst_ovf",   ovf,       1'b0);
    chk("rst_done",  done,      1'b0);
    chk("rst_data",  sif.data,  '0);
    chk("rst_mask",  sif.mask,  '0);
    chk("rst_last",  sif.last,  1'b0);
  endtask

  task automatic issue_start(input logic [W-1:0] s0, input logic [W-1:0] s1, input int len);
    @(posedge clk); #1;
    start = 1'b1; seed0 = s0; seed1 = s1; len_s = LW'(len);
    @(posedge clk); #1;
    start = 1'b0; seed0 = W'($urandom); seed1 = W'($urandom); len_s = LW'($urandom);
  endtask

  task automatic do_run(input logic [W-1:0] s0, input logic [W-1:0] s1, input int len, input bit midstart);
    bit fin_ovf, first_ovf;
    int base, t;
    fin_ovf = model(s0, s1, len, first_ovf);
    base = done_cnt;
    issue_start(s0, s1, len);
    chk("first_valid", sif.valid, (len > 0));
    chk("start_busy", busy, 1'b1);
    chk("ovf_on_start", ovf, first_ovf);
    if (len == 0) chk("done_len0", done, 1'b1);
    if (midstart) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; seed0 = W'($urandom); seed1 = W'($urandom); len_s = LW'($urandom_range(1, 9));
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == base && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_timeout", (done_cnt != base), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", done_cnt - base, 1);
    chk("end_busy", busy, 1'b0);
    chk("end_valid", sif.valid, 1'b0);
    chk("ovf_sticky", ovf, fin_ovf);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int hs0;
    rst_n = 1'b0;
    start = 1'b0;
    seed0 = '0; seed1 = '0; len_s = '0;
    #12;
    check_reset_outs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    do_run(16'd1, 16'd1, 6, 1'b0);
    do_run(16'd1, 16'd1, 5, 1'b0);
    do_run(16'd2, 16'd1, 4, 1'b0);

    hs0 = hs_cnt;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_run(16'd1, 16'd1, 6, 1'b0);
    chk("bp_handshakes", hs_cnt - hs0, 3);

    do_run(16'd1, 16'd1, 24, 1'b0);
    do_run(16'd1, 16'd1, 25, 1'b0);
    do_run(16'd0, 16'd1, 30, 1'b0);
    do_run(16'd3, 16'd4, 0, 1'b0);
    do_run(16'd1, 16'd2, 20, 1'b1);

    begin
      bit fo, f0;
      fo = model(16'd5, 16'd7, 20, f0);
      issue_start(16'd5, 16'd7, 20);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outs();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #4 rst_n = 1'b1;
      #1 check_reset_outs();
    end
    do_run(16'd1, 16'd1, 7, 1'b0);

    rdy_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0] s0, s1;
      if ($urandom_range(0, 1) == 0) begin
        s0 = W'($urandom_range(0, 20));
        s1 = W'($urandom_range(0, 20));
      end else begin
        s0 = W'($urandom);
        s1 = W'($urandom);
      end
      do_run(s0, s1, $urandom_range(0, 23), 1'b0);
    end
    rdy_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
